// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and default widths for the matrix-multiply scheduler.
package matmul_pkg;
   localparam int DIM_W = 32;
   localparam int ADDR_W = 16;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
      logic [ADDR_W-1:0] c_addr;
   } strobe_t;
endpackage

// File: rtl/matmul_sched_delay.sv
// sched_delay: strobe delay line across the memory and MAC stages, with sync clear.
module sched_delay import matmul_pkg::*; #(
   parameter int DEPTH = 5
) (
   input  logic    clk,
   input  logic    reset,
   input  strobe_t d,
   output strobe_t head,
   output strobe_t tail,
   output logic    pending
);
   strobe_t q [DEPTH];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < DEPTH; s++) q[s] <= '0;
      end else begin
         q[0] <= d;
         for (int s = 1; s < DEPTH; s++) q[s] <= q[s-1];
      end
   end
   // The final stage is the write happening now; only earlier stages are still owed.
   always_comb begin
      pending = 1'b0;
      for (int s = 0; s < DEPTH - 1; s++) pending = pending | (q[s].valid & q[s].last);
   end
   assign head = q[0];
   assign tail = q[DEPTH-1];
endmodule

// File: rtl/matmul_sched.sv
// matmul_sched: i/j/k loop-nest scheduler issuing A/B reads, MAC strobes and C writes.
module matmul_sched #(
   parameter int DIM_W   = matmul_pkg::DIM_W,
   parameter int ADDR_W  = matmul_pkg::ADDR_W,
   parameter int MAC_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIM_W-1:0]  num_i,
   input  logic [DIM_W-1:0]  num_j,
   input  logic [DIM_W-1:0]  num_k,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic              mac_valid,
   output logic              mac_first,
   output logic              mac_last,
   output logic              c_we,
   output logic [ADDR_W-1:0] c_addr
);
   import matmul_pkg::*;
   localparam int PW = matmul_pkg::ADDR_W;
   localparam logic [ADDR_W-1:0] A1 = 1;
   localparam logic [DIM_W-1:0] D1 = 1;
   sched_state_t state, state_n;
   logic [DIM_W-1:0] ni, nj, nk, i, j, k;
   logic [ADDR_W-1:0] a_row, c_row, c_cur, nj_a, nk_a;
   logic k_last, j_last, i_last, issue, accept, dims_ok, pending;
   strobe_t d, head, tail;
   assign dims_ok = |num_i && |num_j && |num_k;
   assign accept = state == IDLE && start && dims_ok;
   assign issue = state == RUN && !hold;
   assign k_last = k == nk - D1;
   assign j_last = j == nj - D1;
   assign i_last = i == ni - D1;
   assign nj_a = ADDR_W'(nj);
   assign nk_a = ADDR_W'(nk);
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  state_n = start ? (dims_ok ? RUN : DONE) : IDLE;
         RUN:   state_n = (issue && k_last && j_last && i_last) ? DRAIN : RUN;
         DRAIN: state_n = pending ? DRAIN : DONE;
         DONE:  state_n = IDLE;
      endcase
   end
   // Addresses advance incrementally: a/c from row bases, b by num_j strides.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         {ni, nj, nk, i, j, k} <= '0;
         {a_row, c_row, c_cur, a_addr, b_addr} <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            ni <= num_i;
            nj <= num_j;
            nk <= num_k;
            {i, j, k} <= '0;
            {a_row, c_row, c_cur, a_addr, b_addr} <= '0;
         end else if (issue) begin
            if (!k_last) begin
               k <= k + D1;
               a_addr <= a_addr + A1;
               b_addr <= b_addr + nj_a;
            end else if (!j_last) begin
               k <= '0;
               j <= j + D1;
               a_addr <= a_row;
               b_addr <= ADDR_W'(j + D1);
               c_cur <= c_cur + A1;
            end else begin
               k <= '0;
               j <= '0;
               i <= i + D1;
               a_row <= a_row + nk_a;
               a_addr <= a_row + nk_a;
               b_addr <= '0;
               c_row <= c_row + nj_a;
               c_cur <= c_row + nj_a;
            end
         end
      end
   end
   assign d = '{valid: issue, first: k == '0, last: k_last, c_addr: PW'(c_cur)};
   sched_delay #(.DEPTH(MAC_LAT + 1)) u_delay (
      .clk(clk), .reset(reset), .d(d), .head(head), .tail(tail), .pending(pending)
   );
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign rd_en = issue;
   assign mac_valid = head.valid;
   assign mac_first = head.valid & head.first;
   assign mac_last = head.valid & head.last;
   assign c_we = tail.valid & tail.last;
   assign c_addr = ADDR_W'(tail.c_addr);
endmodule

// File: tb/tb_matmul_sched.sv
// tb_matmul_sched: scoreboard bench; driver queues expected events, monitor checks them.
module tb_matmul_sched;
   localparam int LAT = 4;
   logic clk = 0, reset = 1, start = 0, hold = 0;
   logic [31:0] num_i = 0, num_j = 0, num_k = 0;
   logic busy, done, rd_en, mac_valid, mac_first, mac_last, c_we;
   logic [15:0] a_addr, b_addr, c_addr;
   int cyc = 0, vectors = 0, miscompares = 0;
   typedef struct {int cyc; int x; int y;} ev_t;
   ev_t rd_q[$], mac_q[$], c_q[$];
   int done_q[$];

   matmul_sched #(.DIM_W(32), .ADDR_W(16), .MAC_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .num_i(num_i), .num_j(num_j), .num_k(num_k),
      .hold(hold), .busy(busy), .done(done), .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
      .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last), .c_we(c_we), .c_addr(c_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input string detail);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: %s", name, cyc, detail);
      end
   endtask

   task automatic check_idle(input string name);
      logic [54:0] v;
      v = {busy, done, rd_en, mac_valid, mac_first, mac_last, c_we, a_addr, b_addr, c_addr};
      check(name, v === '0, $sformatf("outputs got %h want 0", v));
   endtask

   // Reference: index decomposition with multiplies, independent of incremental RTL.
   task automatic push_issue(input int t, input int idx, input int ni, input int nj, input int nk);
      int ii, jj, kk;
      ii = idx / (nj * nk);
      jj = (idx / nk) % nj;
      kk = idx % nk;
      rd_q.push_back('{t, ii * nk + kk, kk * nj + jj});
      mac_q.push_back('{t + 1, int'(kk == 0), int'(kk == nk - 1)});
      if (kk == nk - 1) c_q.push_back('{t + 1 + LAT, ii * nj + jj, 0});
   endtask

   task automatic run(input int ni, input int nj, input int nk, input int hold_after,
                      input int hold_len, input bit pulse);
      int n, issued, held, last_t, c0;
      n = ni * nj * nk;
      issued = 0;
      held = 0;
      last_t = 0;
      @(posedge clk); #1;
      c0 = cyc;
      start = 1;
      num_i = ni;
      num_j = nj;
      num_k = nk;
      while (issued < n) begin
         @(posedge clk); #1;
         start = pulse && (cyc == c0 + 2);
         num_i = 1;
         num_j = 1;
         num_k = 1;
         if (issued == hold_after && held < hold_len) begin
            hold = 1;
            held++;
         end else begin
            hold = 0;
            push_issue(cyc, issued, ni, nj, nk);
            issued++;
            last_t = cyc;
         end
      end
      start = 0;
      done_q.push_back(last_t + 2 + LAT);
      while (cyc < last_t + 2 + LAT) begin
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      int dc;
      if (rd_en === 1'b1) begin
         if (rd_q.size() == 0) check("rd_en", 0, "unexpected read issue");
         else begin
            e = rd_q.pop_front();
            check("rd", cyc == e.cyc && a_addr == e.x[15:0] && b_addr == e.y[15:0],
                  $sformatf("got cyc %0d a %0d b %0d want cyc %0d a %0d b %0d",
                            cyc, a_addr, b_addr, e.cyc, e.x, e.y));
         end
      end
      if (mac_valid === 1'b1) begin
         if (mac_q.size() == 0) check("mac_valid", 0, "unexpected MAC strobe");
         else begin
            e = mac_q.pop_front();
            check("mac", cyc == e.cyc && mac_first == e.x[0] && mac_last == e.y[0],
                  $sformatf("got cyc %0d first %0b last %0b want cyc %0d first %0d last %0d",
                            cyc, mac_first, mac_last, e.cyc, e.x, e.y));
         end
      end
      if (c_we === 1'b1) begin
         if (c_q.size() == 0) check("c_we", 0, $sformatf("unexpected write addr %0d", c_addr));
         else begin
            e = c_q.pop_front();
            check("cwr", cyc == e.cyc && c_addr == e.x[15:0],
                  $sformatf("got cyc %0d c_addr %0d want cyc %0d c_addr %0d", cyc, c_addr, e.cyc, e.x));
         end
      end
      if (done === 1'b1) begin
         if (done_q.size() == 0) check("done", 0, "unexpected done");
         else begin
            dc = done_q.pop_front();
            check("done", cyc == dc && busy === 1'b1,
                  $sformatf("got cyc %0d busy %0b want cyc %0d busy 1", cyc, busy, dc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      check_idle("reset_state");
      run(2, 2, 2, -1, 0, 0);
      run(1, 3, 1, -1, 0, 0);
      @(posedge clk); #1;
      c0 = cyc;
      start = 1;
      num_i = 2;
      num_j = 0;
      num_k = 2;
      done_q.push_back(c0 + 1);
      @(posedge clk); #1;
      start = 0;
      check("zero_busy_hi", busy === 1'b1, $sformatf("busy got %b want 1", busy));
      @(posedge clk); #1;
      check("zero_busy_lo", busy === 1'b0, $sformatf("busy got %b want 0", busy));
      run(2, 1, 3, 2, 3, 0);
      run(2, 2, 2, -1, 0, 1);
      @(posedge clk); #1;
      c0 = cyc;
      start = 1;
      num_i = 2;
      num_j = 2;
      num_k = 2;
      @(posedge clk); #1;
      start = 0;
      push_issue(cyc, 0, 2, 2, 2);
      @(posedge clk); #1;
      push_issue(cyc, 1, 2, 2, 2);
      @(posedge clk); #1;
      hold = 1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      hold = 0;
      rd_q.delete();
      mac_q.delete();
      c_q.delete();
      check_idle("reset_mid_run");
      repeat (10) @(posedge clk);
      #1;
      run(1, 2, 2, -1, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rd_q_empty", rd_q.size() == 0, $sformatf("left %0d want 0", rd_q.size()));
      check("mac_q_empty", mac_q.size() == 0, $sformatf("left %0d want 0", mac_q.size()));
      check("c_q_empty", c_q.size() == 0, $sformatf("left %0d want 0", c_q.size()));
      check("done_q_empty", done_q.size() == 0, $sformatf("left %0d want 0", done_q.size()));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
